// File: rtl/tart_raw_buffer.sv
// tart_raw_buffer: antenna/debug sample capture FIFO with a single-outstanding-request read port
module tart_raw_buffer #(
  parameter int AXNUM = 24,
  parameter int ABITS = 9,
  parameter int ADDR  = 25
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             aq_enabled_i,
  input  logic             aq_debug_mode_i,
  input  logic             strobe_i,
  input  logic [AXNUM-1:0] antenna_i,
  input  logic             data_request_i,
  output logic             data_ready_o,
  output logic [AXNUM-1:0] data_o,
  output logic [ADDR-1:0]  aq_adr_o,
  output logic [ABITS:0]   count_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             overflow_o
);
  localparam int PW = ABITS + 1;
  logic [AXNUM-1:0] mem_q [2**ABITS];
  logic             en_q, pend_q, pend_d, rd_q, ready_q, ovf_q, ovf_d;
  logic [ABITS:0]   wptr_q, wptr_d, rptr_q, rptr_d, cnt;
  logic [ADDR-1:0]  adr_q, adr_d;
  logic [AXNUM-1:0] dbg_q, dbg_d, data_q, word;
  logic             rise, cap, full, empty, wr_en, want, rd_en;
  always_comb begin
    rise   = aq_enabled_i && !en_q;
    cap    = strobe_i && aq_enabled_i && en_q;
    cnt    = wptr_q - rptr_q;
    full   = cnt[ABITS];
    empty  = cnt == '0;
    wr_en  = cap && !full;
    // a request stays outstanding from acceptance until its ready pulse has gone
    want   = pend_q || (data_request_i && !rd_q && !ready_q);
    rd_en  = want && !empty && !rise;
    word   = aq_debug_mode_i ? dbg_q : antenna_i;
    pend_d = want && !rd_en && !rise;
    wptr_d = rise ? '0 : wptr_q + PW'(wr_en);
    rptr_d = rise ? '0 : rptr_q + PW'(rd_en);
    adr_d  = rise ? '0 : adr_q + ADDR'(wr_en);
    dbg_d  = rise ? '0 : dbg_q + AXNUM'(cap);
    ovf_d  = !rise && (ovf_q || (cap && full));
  end
  always_ff @(posedge clk_i)
    if (wr_en) mem_q[wptr_q[ABITS-1:0]] <= word;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      en_q    <= 1'b0;
      pend_q  <= 1'b0;
      rd_q    <= 1'b0;
      ready_q <= 1'b0;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      adr_q   <= '0;
      dbg_q   <= '0;
      data_q  <= '0;
    end else begin
      en_q    <= aq_enabled_i;
      pend_q  <= pend_d;
      rd_q    <= rd_en;
      ready_q <= rd_q;
      ovf_q   <= ovf_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      adr_q   <= adr_d;
      dbg_q   <= dbg_d;
      data_q  <= rd_en ? mem_q[rptr_q[ABITS-1:0]] : data_q;
    end
  assign data_ready_o = ready_q;
  assign data_o       = data_q;
  assign aq_adr_o     = adr_q;
  assign count_o      = cnt;
  assign empty_o      = empty;
  assign full_o       = full;
  assign overflow_o   = ovf_q;
endmodule

// File: tb/tb_tart_raw_buffer.sv
// tb_tart_raw_buffer: directed and randomized checks of tart_raw_buffer against a queue model
module tb_tart_raw_buffer;
  localparam int AX = 24, AB = 9, AD = 25, DEPTH = 2**AB;
  logic clk_i = 0, rst_ni = 1, aq_enabled_i = 0, aq_debug_mode_i = 0, strobe_i = 0, data_request_i = 0;
  logic [AX-1:0] antenna_i = '0;
  logic data_ready_o, empty_o, full_o, overflow_o;
  logic [AX-1:0] data_o;
  logic [AD-1:0] aq_adr_o;
  logic [AB:0] count_o;
  int tests = 0, failed = 0;
  logic [AX-1:0] q[$];
  int m_adr = 0, m_dbg = 0;
  bit m_ovf = 0;
  always #5 clk_i = ~clk_i;
  tart_raw_buffer #(.AXNUM(AX), .ABITS(AB), .ADDR(AD)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .aq_enabled_i(aq_enabled_i), .aq_debug_mode_i(aq_debug_mode_i),
    .strobe_i(strobe_i), .antenna_i(antenna_i), .data_request_i(data_request_i),
    .data_ready_o(data_ready_o), .data_o(data_o), .aq_adr_o(aq_adr_o), .count_o(count_o),
    .empty_o(empty_o), .full_o(full_o), .overflow_o(overflow_o)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic clear_model();
    q.delete();
    m_adr = 0;
    m_ovf = 0;
    m_dbg = 0;
  endtask
  task automatic enable(input bit dbg);
    aq_debug_mode_i = dbg;
    aq_enabled_i = 0;
    tick();
    aq_enabled_i = 1;
    tick();
    clear_model();
  endtask
  task automatic strobe(input logic [AX-1:0] w);
    antenna_i = w;
    strobe_i = 1;
    tick();
    strobe_i = 0;
    if (aq_enabled_i) begin
      if (q.size() < DEPTH) begin
        q.push_back(aq_debug_mode_i ? AX'(m_dbg) : w);
        m_adr++;
      end else m_ovf = 1;
      m_dbg++;
    end
  endtask
  task automatic check_status(input string tag);
    check({tag, ".count"}, count_o, q.size());
    check({tag, ".adr"}, aq_adr_o, m_adr % (1 << AD));
    check({tag, ".ovf"}, overflow_o, m_ovf);
    check({tag, ".empty"}, empty_o, q.size() == 0);
    check({tag, ".full"}, full_o, q.size() == DEPTH);
  endtask
  task automatic check_reset(input string tag);
    check({tag, ".ready"}, data_ready_o, 0);
    check({tag, ".data"}, data_o, 0);
    check({tag, ".adr"}, aq_adr_o, 0);
    check({tag, ".count"}, count_o, 0);
    check({tag, ".empty"}, empty_o, 1);
    check({tag, ".full"}, full_o, 0);
    check({tag, ".ovf"}, overflow_o, 0);
  endtask
  task automatic read(input string tag);
    int lat;
    logic [AX-1:0] exp;
    exp = q.pop_front();
    data_request_i = 1;
    tick();
    data_request_i = 0;
    lat = 1;
    while (!data_ready_o && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, ".lat"}, lat, 2);
    check({tag, ".data"}, data_o, exp);
    tick();
    check({tag, ".pulse"}, data_ready_o, 0);
    check({tag, ".hold"}, data_o, exp);
  endtask
  initial begin
    int pulses, first, n;
    #2 rst_ni = 0;
    tick();
    check_reset("rst");
    rst_ni = 1;
    enable(1);
    for (int i = 0; i < 5; i++) strobe(AX'($urandom));
    check_status("dbg5");
    for (int i = 0; i < 5; i++) read($sformatf("dbg_rd%0d", i));
    check_status("dbg5.after");
    enable(0);
    strobe(24'hA5A5A5);
    read("a5");
    check_status("a5.after");
    data_request_i = 1;
    tick();
    data_request_i = 0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      data_request_i = (i == 3);
      tick();
      data_request_i = 0;
      pulses += int'(data_ready_o);
    end
    check("wait.idle", pulses, 0);
    strobe(24'h123456);
    pulses = 0;
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (data_ready_o) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    check("wait.pulses", pulses, 1);
    check("wait.first", first, 2);
    check("wait.data", data_o, q.pop_front());
    for (int k = 0; k < 25; k++) begin
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) strobe(AX'($urandom));
      n = $urandom_range(0, q.size());
      for (int i = 0; i < n; i++) read($sformatf("rnd%0d_%0d", k, i));
      check($sformatf("rnd%0d.count", k), count_o, q.size());
    end
    enable(0);
    check_status("fill.start");
    for (int i = 0; i < DEPTH + 1; i++) strobe(AX'($urandom));
    check_status("fill");
    read("fill.first");
    check_status("fill.after");
    aq_enabled_i = 0;
    tick();
    strobe(AX'($urandom));
    check_status("disabled");
    aq_debug_mode_i = 1;
    aq_enabled_i = 1;
    tick();
    clear_model();
    check_status("reen");
    for (int i = 0; i < 3; i++) strobe(AX'($urandom));
    check_status("reen3");
    for (int i = 0; i < 3; i++) read($sformatf("reen_rd%0d", i));
    data_request_i = 1;
    tick();
    data_request_i = 0;
    tick();
    #3 rst_ni = 0;
    #1;
    check_reset("async");
    tick();
    tick();
    rst_ni = 1;
    clear_model();
    enable(0);
    strobe(AX'($urandom));
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      pulses += int'(data_ready_o);
    end
    check("async.nopulse", pulses, 0);
    check_status("async.after");
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
